// File: rtl/cache_controller_pkg.sv
// Shared constants and FSM encoding for the data-cache controller.
package cache_controller_pkg;

  localparam logic [31:0] MEM_BASE = 32'd1024;
  localparam int          ADDR_W   = 17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    FILL      = 2'd2,
    WRITE     = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of pipeline, cache and SRAM signals around the cache controller.
// Handshake: the pipeline holds address/wdata/enables while ready=0; an SRAM op is a
// level request (sram_*_en) held until a one-cycle sram_ready pulse completes it.
interface cache_controller_if #(
  parameter int ADDR_W = 17
);
  logic [31:0]       address;
  logic [31:0]       wdata;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] cache_address;
  logic [63:0]       cache_write_data;
  logic              cache_read_en;
  logic              cache_write_en;
  logic              cache_invoke_en;
  logic [31:0]       cache_read_data;
  logic              cache_hit;
  logic [31:0]       sram_address;
  logic [31:0]       sram_wdata;
  logic              sram_read_en;
  logic              sram_write_en;
  logic [63:0]       sram_rdata;
  logic              sram_ready;

  modport master (
    output address, wdata, MEM_R_EN, MEM_W_EN, cache_read_data, cache_hit,
           sram_rdata, sram_ready,
    input  rdata, ready, cache_address, cache_write_data, cache_read_en,
           cache_write_en, cache_invoke_en, sram_address, sram_wdata,
           sram_read_en, sram_write_en
  );

  modport slave (
    input  address, wdata, MEM_R_EN, MEM_W_EN, cache_read_data, cache_hit,
           sram_rdata, sram_ready,
    output rdata, ready, cache_address, cache_write_data, cache_read_en,
           cache_write_en, cache_invoke_en, sram_address, sram_wdata,
           sram_read_en, sram_write_en
  );
endinterface

// File: rtl/cache_controller.sv
// Read-allocate, write-through (no write-allocate) controller for a 2-way data cache.
// Hits answer in the same cycle; misses and stores freeze the pipeline via ready.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = cache_controller_pkg::MEM_BASE,
  parameter int          ADDR_W   = cache_controller_pkg::ADDR_W
) (
  input  logic           clk,
  input  logic           rst,
  cache_controller_if.slave bus,
  output state_t         dbg_state
);

  state_t            state;
  logic [63:0]       line_q;
  logic [ADDR_W-1:0] word;
  logic              offset;
  logic              rd_req;
  logic              wr_req;

  assign word   = ADDR_W'((bus.address - MEM_BASE) >> 2);
  assign offset = word[0];
  // A store wins when both enables are raised.
  assign wr_req = bus.MEM_W_EN;
  assign rd_req = bus.MEM_R_EN & ~bus.MEM_W_EN;

  assign bus.cache_address    = word;
  assign bus.cache_write_data = line_q;
  assign bus.sram_address     = bus.address;
  assign bus.sram_wdata       = bus.wdata;
  assign dbg_state            = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      line_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_req)
            state <= WRITE;
          else if (rd_req && !bus.cache_hit)
            state <= READ_MISS;
        end
        READ_MISS: begin
          if (bus.sram_ready) begin
            line_q <= bus.sram_rdata;
            state  <= FILL;
          end
        end
        FILL:    state <= IDLE;
        WRITE:   if (bus.sram_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend on live inputs so hits and store completion cost no extra cycle.
  always_comb begin
    bus.ready           = 1'b1;
    bus.rdata           = '0;
    bus.cache_read_en   = 1'b0;
    bus.cache_write_en  = 1'b0;
    bus.cache_invoke_en = 1'b0;
    bus.sram_read_en    = 1'b0;
    bus.sram_write_en   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          bus.ready           = 1'b0;
          bus.cache_invoke_en = bus.cache_hit;
        end else if (rd_req) begin
          if (bus.cache_hit) begin
            bus.rdata         = bus.cache_read_data;
            bus.cache_read_en = 1'b1;
          end else begin
            bus.ready = 1'b0;
          end
        end
      end
      READ_MISS: begin
        bus.sram_read_en = 1'b1;
        bus.ready        = 1'b0;
      end
      FILL: begin
        bus.cache_write_en = 1'b1;
        bus.rdata          = offset ? line_q[63:32] : line_q[31:0];
      end
      WRITE: begin
        bus.sram_write_en = 1'b1;
        bus.ready         = bus.sram_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: cache and SRAM responses are driven by hand.
module tb_cache_controller
  import cache_controller_pkg::*;
;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;
  int     stall    = 0;

  cache_controller_if bus ();

  cache_controller dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {cache_read_en, cache_write_en, cache_invoke_en, sram_read_en, sram_write_en}
  function automatic logic [4:0] strobes();
    return {bus.cache_read_en, bus.cache_write_en, bus.cache_invoke_en,
            bus.sram_read_en, bus.sram_write_en};
  endfunction

  initial begin
    rst                 = 1'b1;
    bus.address         = 32'd1024;
    bus.wdata           = '0;
    bus.MEM_R_EN        = 1'b0;
    bus.MEM_W_EN        = 1'b0;
    bus.cache_read_data = '0;
    bus.cache_hit       = 1'b0;
    bus.sram_rdata      = '0;
    bus.sram_ready      = 1'b0;

    // Reset state
    cyc();
    cyc();
    #1;
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_strobes", 64'(strobes()), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    rst = 1'b0;

    // Idle for 10 cycles, with a stray sram_ready that must be ignored
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.sram_ready = (i == 4);
      #1;
      check("idle_ready", 64'(bus.ready), 64'd1);
      check("idle_strobes", 64'(strobes()), 64'd0);
      check("idle_state", 64'(dbg_state), 64'(IDLE));
    end

    // Read miss at 1032, SRAM answers {7,5} in the 4th READ_MISS cycle
    cyc();
    bus.sram_ready = 1'b0;
    bus.address    = 32'd1032;
    bus.MEM_R_EN   = 1'b1;
    bus.cache_hit  = 1'b0;
    #1;
    check("miss0_caddr", 64'(bus.cache_address), 64'd2);
    check("miss0_strobes", 64'(strobes()), 64'd0);
    if (!bus.ready) stall++;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) begin
        bus.sram_ready = 1'b1;
        bus.sram_rdata = {32'd7, 32'd5};
      end
      #1;
      check("miss_state", 64'(dbg_state), 64'(READ_MISS));
      check("miss_strobes", 64'(strobes()), 64'b00010);
      if (!bus.ready) stall++;
    end
    cyc();
    bus.sram_ready = 1'b0;
    bus.sram_rdata = 64'hdead_beef_cafe_f00d;
    #1;
    check("miss_stall_cycles", 64'(stall), 64'd5);
    check("fill_state", 64'(dbg_state), 64'(FILL));
    check("fill_strobes", 64'(strobes()), 64'b01000);
    check("fill_wdata", bus.cache_write_data, {32'd7, 32'd5});
    check("fill_rdata", 64'(bus.rdata), 64'd5);
    check("fill_ready", 64'(bus.ready), 64'd1);
    check("fill_caddr", 64'(bus.cache_address), 64'd2);

    // Hit on the neighbouring word
    cyc();
    bus.address         = 32'd1036;
    bus.cache_hit       = 1'b1;
    bus.cache_read_data = 32'd7;
    #1;
    check("hit_state", 64'(dbg_state), 64'(IDLE));
    check("hit_ready", 64'(bus.ready), 64'd1);
    check("hit_rdata", 64'(bus.rdata), 64'd7);
    check("hit_caddr", 64'(bus.cache_address), 64'd3);
    check("hit_strobes", 64'(strobes()), 64'b10000);

    // Write hit at 1032: invalidate once, SRAM write completes on the 3rd WRITE cycle
    cyc();
    check("hit_stays_idle", 64'(dbg_state), 64'(IDLE));
    bus.address  = 32'd1032;
    bus.wdata    = 32'd9;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b1;
    bus.cache_hit = 1'b1;
    #1;
    check("wr_hit_strobes", 64'(strobes()), 64'b00100);
    check("wr_hit_ready", 64'(bus.ready), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      bus.cache_hit  = 1'b0;
      bus.sram_ready = (i == 3);
      #1;
      check("wr_state", 64'(dbg_state), 64'(WRITE));
      check("wr_strobes", 64'(strobes()), 64'b00001);
      check("wr_saddr", 64'(bus.sram_address), 64'd1032);
      check("wr_swdata", 64'(bus.sram_wdata), 64'd9);
      check("wr_ready", 64'(bus.ready), (i == 3) ? 64'd1 : 64'd0);
    end

    // Re-read of 1032 misses, then reset lands in the 2nd READ_MISS cycle
    cyc();
    bus.sram_ready = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.MEM_R_EN   = 1'b1;
    bus.cache_hit  = 1'b0;
    #1;
    check("reread_ready", 64'(bus.ready), 64'd0);
    check("reread_strobes", 64'(strobes()), 64'd0);
    cyc();
    #1;
    check("reread_state", 64'(dbg_state), 64'(READ_MISS));
    cyc();
    rst = 1'b1;
    #1;
    check("rstmid_sram_rd_held", 64'(bus.sram_read_en), 64'd1);
    cyc();
    rst          = 1'b0;
    bus.MEM_R_EN = 1'b0;
    #1;
    check("rstmid_state", 64'(dbg_state), 64'(IDLE));
    check("rstmid_strobes", 64'(strobes()), 64'd0);
    check("rstmid_ready", 64'(bus.ready), 64'd1);
    cyc();
    bus.sram_ready = 1'b1;
    bus.sram_rdata = {32'd1, 32'd2};
    #1;
    check("rstmid_late_sram_ready", 64'(strobes()), 64'd0);
    cyc();
    bus.sram_ready = 1'b0;
    #1;
    check("rstmid_no_fill", 64'(dbg_state), 64'(IDLE));

    // Write miss at 2048
    cyc();
    bus.address  = 32'd2048;
    bus.wdata    = 32'h1234;
    bus.MEM_W_EN = 1'b1;
    #1;
    check("wrmiss_caddr", 64'(bus.cache_address), 64'd256);
    check("wrmiss_strobes", 64'(strobes()), 64'd0);
    check("wrmiss_ready", 64'(bus.ready), 64'd0);
    cyc();
    bus.sram_ready = 1'b1;
    #1;
    check("wrmiss_done_strobes", 64'(strobes()), 64'b00001);
    check("wrmiss_done_ready", 64'(bus.ready), 64'd1);
    check("wrmiss_swdata", 64'(bus.sram_wdata), 64'h1234);
    cyc();
    bus.sram_ready = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    #1;
    check("wrmiss_back_idle", 64'(dbg_state), 64'(IDLE));
    check("wrmiss_en_dropped", 64'(strobes()), 64'd0);

    // Both enables high: store path wins
    cyc();
    bus.address   = 32'd1036;
    bus.MEM_R_EN  = 1'b1;
    bus.MEM_W_EN  = 1'b1;
    bus.cache_hit = 1'b1;
    #1;
    check("both_strobes", 64'(strobes()), 64'b00100);
    check("both_ready", 64'(bus.ready), 64'd0);
    cyc();
    bus.cache_hit  = 1'b0;
    bus.sram_ready = 1'b1;
    #1;
    check("both_state", 64'(dbg_state), 64'(WRITE));
    check("both_sram_en", 64'(strobes()), 64'b00001);
    cyc();
    bus.sram_ready = 1'b0;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    #1;
    check("both_back_idle", 64'(dbg_state), 64'(IDLE));

    // Enable dropped mid-miss: fill still happens, odd word selected
    cyc();
    bus.address  = 32'd1044;
    bus.MEM_R_EN = 1'b1;
    #1;
    check("drop_caddr", 64'(bus.cache_address), 64'd5);
    cyc();
    bus.MEM_R_EN   = 1'b0;
    bus.sram_ready = 1'b1;
    bus.sram_rdata = {32'haaaa_0001, 32'hbbbb_0002};
    #1;
    check("drop_state", 64'(dbg_state), 64'(READ_MISS));
    cyc();
    bus.sram_ready = 1'b0;
    #1;
    check("drop_fill_strobes", 64'(strobes()), 64'b01000);
    check("drop_fill_rdata", 64'(bus.rdata), 64'haaaa_0001);
    cyc();
    #1;
    check("drop_back_idle", 64'(dbg_state), 64'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sits between the MEM stage and the SRAM controller.
- Drives the 2-way, 64-set data cache (17-bit word address, 64-bit line = 2 words).
- Policy: read-allocate and write-through with no write-allocate. A write hit invalidates the cached line.
- Generates the `ready` freeze signal back to the pipeline.

Parameters:
- MEM_BASE, 1024: byte address of data memory start; subtracted before indexing.
- ADDR_W, 17: cache/SRAM word-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- address  in  32  byte address from MEM stage; held stable while ready=0
- wdata  in  32  store data; held stable while ready=0
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- rdata  out  32  load result; valid when ready=1 and MEM_R_EN=1
- ready  out  1  0 freezes pipeline
- cache_address  out  17  word address to cache; `((address-MEM_BASE)>>2)[16:0]`
- cache_write_data  out  64  line fill data (= sram_rdata)
- cache_read_en  out  1  read strobe for LRU update
- cache_write_en  out  1  line fill strobe
- cache_invoke_en  out  1  invalidate strobe
- cache_read_data  in  32  word from cache
- cache_hit  in  1  combinational hit from cache
- sram_address  out  32  forwarded byte address
- sram_wdata  out  32  forwarded store data
- sram_read_en  out  1  SRAM line read request
- sram_write_en  out  1  SRAM word write request
- sram_rdata  in  64  line read from SRAM; `{word1, word0}`
- sram_ready  in  1  1-cycle pulse: SRAM op complete

Behaviour:
- Reset: state=IDLE. All strobes and sram_*_en are 0, ready=1, rdata=0.
- Address math: `word = (address - MEM_BASE) >> 2`. `cache_address = word[16:0]`; `offset = word[0]`.
- No request (MEM_R_EN=MEM_W_EN=0): ready=1, no strobes.
- MEM_W_EN has priority if both enables are high.
- State IDLE:
  - Read and cache_hit:
    - Same-cycle response: ready=1, rdata=cache_read_data, cache_read_en=1.
    - Zero stall; state stays IDLE.
  - Read and !cache_hit:
    - ready=0, go to READ_MISS.
  - Write:
    - ready=0, cache_invoke_en=cache_hit for this cycle only, go to WRITE.
- State READ_MISS:
  - sram_read_en=1, ready=0.
  - On sram_ready=1, go to FILL.
  - sram_rdata is captured into a 64-bit line register on that edge.
- State FILL (exactly 1 cycle):
  - cache_write_en=1, cache_write_data=line register.
  - rdata = offset ? line[63:32] : line[31:0]; ready=1.
  - Next state IDLE. The pipeline advances on the same edge the cache is written.
- State WRITE:
  - sram_write_en=1, with sram_address/sram_wdata driven from the inputs.
  - ready = sram_ready.
  - On sram_ready=1, go to IDLE. No cache write.
- sram_*_en are level signals: held until sram_ready, deasserted the cycle after.
- sram_ready outside READ_MISS/WRITE is ignored.
- Enable deasserted mid-miss (illegal per hold rule): the SRAM op still completes, FILL still occurs, and the result is discarded by the pipeline.
- rst mid-operation:
  - Immediate return to IDLE; enables drop the next cycle.
  - The line register and any partial fill are abandoned, and no cache write occurs.
- cache_write_en and cache_invoke_en are never asserted in the same cycle.
- cache_read_en is never asserted on a miss.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, READ_MISS=2'd1, FILL=2'd2, WRITE=2'd3.
  - MEM_BASE.
- No sub-module; the address translator is an inline continuous assignment.

Test Plan:
- Read miss then hit:
  - Stimulus: MEM_R_EN with address=1032; SRAM returns sram_rdata=`{32'd7, 32'd5}` after 4 cycles.
  - Response: ready=0 for 5 cycles, then a FILL cycle with cache_write_en=1, rdata=5, cache_address=2.
  - Follow-up: read address=1036 next → hit, rdata=7, ready=1 same cycle, no sram_read_en.
- Write hit:
  - Stimulus: after the fill above, MEM_W_EN with address=1032, wdata=9.
  - Response: cache_invoke_en=1 for one cycle, sram_write_en held until sram_ready, ready=1 only in the sram_ready cycle.
  - Follow-up: a subsequent read of 1032 misses.
- Write miss:
  - Stimulus: address=2048.
  - Response: cache_invoke_en=0, cache_write_en never asserted, SRAM write completes.
- Idle:
  - Stimulus: enables low for 10 cycles.
  - Response: ready=1, all strobes 0.
- Reset mid-miss:
  - Stimulus: assert rst in cycle 2 of READ_MISS.
  - Response: state IDLE, sram_read_en=0 next cycle, no cache_write_en, ready=1.
- Both enables:
  - Stimulus: MEM_R_EN=MEM_W_EN=1.
  - Response: write path taken (sram_write_en=1, sram_read_en=0).
